scroll_sequencer: RTL and testbench



---
 rtl/scroll_sequencer_pkg.sv | 26 ++
 rtl/scroll_sequencer_if.sv | 28 ++
 rtl/scroll_sequencer_edge_detect.sv | 23 ++
 rtl/scroll_sequencer.sv | 143 ++++++++++++++
 tb/tb_scroll_sequencer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/scroll_sequencer_pkg.sv
// Shared definitions for the scroll sequencer: state encoding, pattern count
// and default widths, plus the pattern-index wrap helper.
package scroll_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_t;

  localparam int PATTERN_COUNT = 4;
  localparam int XW_DEFAULT    = 10;
  localparam int FW_DEFAULT    = 9;

  // Next pattern index, wrapping after the last pattern.
  function automatic logic [1:0] next_pattern(input logic [1:0] cur);
    logic [1:0] last;
    last = 2'(PATTERN_COUNT - 1);
    if (cur == last) begin
      return 2'd0;
    end else begin
      return cur + 2'd1;
    end
  endfunction

endpackage

// File: rtl/scroll_sequencer_if.sv
// Control/status bundle between the frame-rate sequencer and its neighbours.
// The slave modport is the sequencer side; master is the driving side.
interface scroll_sequencer_if #(
  parameter int XW = 10,
  parameter int FW = 9
);
  logic          vsync;
  logic [2:0]    speed;
  logic          dir;
  logic          pause;
  logic          step;
  logic [XW-1:0] scroll_x;
  logic [XW-1:0] scroll_y;
  logic [1:0]    pattern_sel;
  logic [FW-1:0] frame_no;
  logic          frame_tick;
  logic          running;

  modport master (
    output vsync, speed, dir, pause, step,
    input  scroll_x, scroll_y, pattern_sel, frame_no, frame_tick, running
  );

  modport slave (
    input  vsync, speed, dir, pause, step,
    output scroll_x, scroll_y, pattern_sel, frame_no, frame_tick, running
  );
endinterface

// File: rtl/scroll_sequencer_edge_detect.sv
// Rising-edge detector. The previous-value register resets to PREV_RST so a
// level already high at reset release does not produce a false edge.
module edge_detect #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;

  // Remember last cycle's input level.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= PREV_RST;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/scroll_sequencer.sv
// Frame-rate sequencer for the VGA pattern datapath: detects the vsync rising
// edge in the pixel clock domain and advances scroll offset, pattern index and
// frame counter through an IDLE/RUN/PAUSE state machine.
// Optional: define SCROLL_SEQ_VSCROLL_EN to enable vertical scrolling
// (scroll_y counts advances); otherwise scroll_y is constant 0.
module scroll_sequencer
  import scroll_sequencer_pkg::*;
#(
  parameter int XW           = XW_DEFAULT,
  parameter int FW           = FW_DEFAULT,
  parameter int DWELL_FRAMES = 120
) (
  input  logic              clk,
  input  logic              reset,
  scroll_sequencer_if.slave bus
);
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  logic          fe;
  logic          step_rise;
  seq_state_t    state;
  logic [XW-1:0] scroll_x;
  logic [1:0]    pattern_sel;
  logic [FW-1:0] frame_no;
  logic          frame_tick;
  logic          running;
  logic          step_pend;
  logic [DW-1:0] dwell_cnt;
  logic          advance;
  logic          step_pend_next;
  logic [XW-1:0] step_amt;

  edge_detect #(.PREV_RST(1'b1)) u_vsync_edge (
    .clk(clk), .reset(reset), .d(bus.vsync), .rise(fe)
  );

  edge_detect #(.PREV_RST(1'b1)) u_step_edge (
    .clk(clk), .reset(reset), .d(bus.step), .rise(step_rise)
  );

  assign step_amt = XW'(bus.speed);

  // Decide whether this frame edge moves the pattern forward.
  always_comb begin
    advance = 1'b0;
    if (fe) begin
      case (state)
        ST_RUN:   advance = ~bus.pause;
        ST_PAUSE: advance = ~bus.pause | step_pend;
        default:  advance = 1'b0;
      endcase
    end else begin
      advance = 1'b0;
    end
  end

  // Single-step request: only meaningful in PAUSE; a new edge in the same
  // cycle as a consuming frame edge is kept for the following frame.
  always_comb begin
    step_pend_next = step_pend;
    if (state != ST_PAUSE) begin
      step_pend_next = 1'b0;
    end else if (fe && !bus.pause) begin
      step_pend_next = 1'b0;
    end else if (step_rise) begin
      step_pend_next = 1'b1;
    end else if (fe && step_pend) begin
      step_pend_next = 1'b0;
    end else begin
      step_pend_next = step_pend;
    end
  end

  // State machine and all frame-rate registers, committed on the frame edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      running     <= 1'b0;
      frame_tick  <= 1'b0;
      frame_no    <= {FW{1'b0}};
      scroll_x    <= {XW{1'b0}};
      pattern_sel <= 2'd0;
      dwell_cnt   <= {DW{1'b0}};
      step_pend   <= 1'b0;
    end else begin
      frame_tick <= fe;
      step_pend  <= step_pend_next;
      if (fe) begin
        frame_no <= frame_no + {{(FW-1){1'b0}}, 1'b1};
        case (state)
          ST_IDLE: begin
            state   <= bus.pause ? ST_PAUSE : ST_RUN;
            running <= ~bus.pause;
          end
          ST_RUN: begin
            state   <= bus.pause ? ST_PAUSE : ST_RUN;
            running <= ~bus.pause;
          end
          ST_PAUSE: begin
            state   <= bus.pause ? ST_PAUSE : ST_RUN;
            running <= ~bus.pause;
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
      if (advance) begin
        scroll_x <= bus.dir ? (scroll_x - step_amt) : (scroll_x + step_amt);
        if (dwell_cnt == DW'(DWELL_FRAMES - 1)) begin
          dwell_cnt   <= {DW{1'b0}};
          pattern_sel <= next_pattern(pattern_sel);
        end else begin
          dwell_cnt <= dwell_cnt + {{(DW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

`ifdef SCROLL_SEQ_VSCROLL_EN
  logic [XW-1:0] scroll_y;

  // Vertical offset steps by one on every advance, regardless of speed/dir.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_y <= {XW{1'b0}};
    end else if (advance) begin
      scroll_y <= scroll_y + {{(XW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.scroll_y = scroll_y;
`else
  assign bus.scroll_y = {XW{1'b0}};
`endif

  assign bus.scroll_x    = scroll_x;
  assign bus.pattern_sel = pattern_sel;
  assign bus.frame_no    = frame_no;
  assign bus.frame_tick  = frame_tick;
  assign bus.running     = running;
endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer with DWELL_FRAMES=4; expected values
// are hand-computed from the frame/advance sequence below.
module tb_scroll_sequencer;
  localparam int XW = 10;
  localparam int FW = 9;
`ifdef SCROLL_SEQ_VSCROLL_EN
  localparam int VS = 1;
`else
  localparam int VS = 0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   tick_cnt;
  int   tick_base;

  scroll_sequencer_if #(.XW(XW), .FW(FW)) bus ();

  scroll_sequencer #(.XW(XW), .FW(FW), .DWELL_FRAMES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_tick pulses, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.frame_tick) tick_cnt = tick_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk); bus.vsync = 1'b1;
    @(negedge clk); bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_step();
    @(negedge clk); bus.step = 1'b1;
    @(negedge clk); bus.step = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input int x, input int pat,
                             input int fno, input int run);
    check({tag, "_x"},   32'(bus.scroll_x),    32'(x));
    check({tag, "_pat"}, 32'(bus.pattern_sel), 32'(pat));
    check({tag, "_fno"}, 32'(bus.frame_no),    32'(fno));
    check({tag, "_run"}, 32'(bus.running),     32'(run));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; tick_cnt = 0; tick_base = 0;
    reset = 1'b1;
    bus.vsync = 1'b0; bus.speed = 3'd0; bus.dir = 1'b0;
    bus.pause = 1'b0; bus.step = 1'b0;
    repeat (2) @(negedge clk);
    check_state("rst", 0, 0, 0, 0);
    check("rst_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_y", 32'(bus.scroll_y), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Startup: first frame only aligns, then +2 per frame.
    bus.speed = 3'd2; bus.dir = 1'b0;
    frame(); check_state("f1", 0, 0, 1, 1);
    frame(); check_state("f2", 2, 0, 2, 1);
    frame(); check_state("f3", 4, 0, 3, 1);
    check("tick3", 32'(tick_cnt), 32'd3);
    check("tick_low", 32'(bus.frame_tick), 32'd0);

    // Wrap in both directions.
    bus.speed = 3'd6; bus.dir = 1'b1;
    frame(); check_state("w1", 1022, 0, 4, 1);
    bus.speed = 3'd3; bus.dir = 1'b0;
    frame(); check_state("w2", 1, 1, 5, 1);
    bus.speed = 3'd5; bus.dir = 1'b1;
    frame(); check_state("w3", 1020, 1, 6, 1);

    // Pause, single step, resume.
    bus.pause = 1'b1;
    frame(); check_state("p1", 1020, 1, 7, 0);
    frame(); check_state("p2", 1020, 1, 8, 0);
    pulse_step(); pulse_step();
    frame(); check_state("p3", 1015, 1, 9, 0);
    frame(); check_state("p4", 1015, 1, 10, 0);
    bus.pause = 1'b0;
    frame(); check_state("p5", 1010, 1, 11, 1);
    frame(); check_state("p6", 1005, 2, 12, 1);

    // Step while running is discarded.
    pulse_step();
    bus.pause = 1'b1;
    frame(); check_state("d1", 1005, 2, 13, 0);
    frame(); check_state("d2", 1005, 2, 14, 0);

    // Step edge coincident with the frame edge is serviced one frame later.
    @(negedge clk); bus.vsync = 1'b1; bus.step = 1'b1;
    @(negedge clk); bus.vsync = 1'b0; bus.step = 1'b0;
    repeat (3) @(negedge clk);
    check_state("s1", 1005, 2, 15, 0);
    frame(); check_state("s2", 1000, 2, 16, 0);

    // Long vsync high: exactly one frame edge.
    bus.pause = 1'b0;
    tick_base = tick_cnt;
    @(negedge clk); bus.vsync = 1'b1;
    repeat (50) @(negedge clk);
    bus.vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("long_tick", 32'(tick_cnt - tick_base), 32'd1);
    check_state("long", 995, 2, 17, 1);
    check("y10", 32'(bus.scroll_y), 32'(10 * VS));

    // Mid-frame reset, then re-pass through IDLE.
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_state("mr", 0, 0, 0, 0);
    check("mr_y", 32'(bus.scroll_y), 32'd0);
    check("mr_tick", 32'(bus.frame_tick), 32'd0);
    reset = 1'b0;
    frame(); check_state("r1", 0, 0, 1, 1);
    check("r1_y", 32'(bus.scroll_y), 32'd0);
    frame(); check_state("r2", 1019, 0, 2, 1);
    check("r2_y", 32'(bus.scroll_y), 32'(VS));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
